rll_key_loader: RTL and testbench
=================================

RLL_KEY_LOADER -- requirements
Module: rll_key_loader

Interface
REQ-001 Parameter KEY_W, default 16, SHALL set the key width, one bit per keyIn_0_<i> input of the locked netlist.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum idle cycles allowed between accepted serial bits.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  in  1  SHALL be a level sampled each cycle; high begins a key load.
REQ-006 key_bit  in  1  SHALL carry serial key data from key storage, LSB first, followed by one even-parity bit.
REQ-007 key_bit_valid  in  1  SHALL mark key_bit as valid.
REQ-008 key_bit_ready  out  1  SHALL indicate that the loader accepts a bit this cycle.
REQ-009 key_out  out  KEY_W  SHALL drive keyIn_0_0..keyIn_0_<KEY_W-1>; bit i drives keyIn_0_i.
REQ-010 key_valid  out  1  SHALL be high only while key_out holds a parity-checked key.
REQ-011 busy  out  1  SHALL be high in SHIFT and CHECK.
REQ-012 err  out  1  SHALL be high in ERROR.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, CHECK, LOADED and ERROR.
REQ-014 IDLE->SHIFT SHALL occur on the edge where start=1; the bit counter and timeout counter clear on that edge.
REQ-015 In SHIFT, key_bit_ready SHALL be 1; a transfer SHALL occur when key_bit_valid and key_bit_ready are both 1.
REQ-016 Each transfer SHALL shift key_bit into a KEY_W+1-bit shadow register at the MSB end and increment the bit counter (width ceil(log2(KEY_W+2))).
REQ-017 The transfer that brings the counter to KEY_W+1 SHALL move the FSM to CHECK on the same edge.
REQ-018 In CHECK, lasting exactly one cycle, the XOR of all KEY_W+1 shadow bits SHALL be computed; 0 -> LOADED, 1 -> ERROR.
REQ-019 On entry to LOADED, key_out SHALL load the shadow bits [KEY_W-1:0] and key_valid SHALL rise the same cycle.
REQ-020 key_out SHALL be all-zero in every state except LOADED, so the locked netlist never sees a partial key.
REQ-021 In SHIFT, the timeout counter SHALL increment on each cycle without a transfer and clear on each transfer.
REQ-022 When the timeout counter reaches TIMEOUT in SHIFT, the FSM SHALL go to ERROR; a transfer on that same cycle takes priority and clears the counter.
REQ-023 start SHALL be ignored in SHIFT and CHECK.
REQ-024 start=1 in LOADED or ERROR SHALL go to SHIFT, clearing key_out, key_valid and err on that edge.
REQ-025 key_bit_ready SHALL be 0 outside SHIFT, and key_bit_valid SHALL be ignored there.
REQ-026 Minimum load latency SHALL be KEY_W+3 cycles from the start edge to key_valid=1 (KEY_W+1 transfers, then CHECK).

Reset
REQ-027 rst=1 SHALL immediately set state IDLE, key_out=0, key_valid=0, busy=0, err=0, key_bit_ready=0 and both counters to 0, and clear the shadow register.
REQ-028 Reset asserted mid-load SHALL discard all shifted bits; no partial key reaches key_out.
REQ-029 Reset deassertion SHALL be synchronised externally; the block adds no synchroniser.

Structure
REQ-030 State encoding typedef and default KEY_W/TIMEOUT constants SHALL live in shared package rll_key_pkg.
REQ-031 The serial shift/parity datapath SHALL be a sub-module rll_key_shreg; the FSM and counters stay in rll_key_loader.
REQ-032 The design SHALL be synthesisable, single clock domain, with no latches.

Verification
REQ-033 Key 16'hA5C3 (parity bit 0), valid held high -> key_valid=1 exactly 19 cycles after the start edge, key_out=16'hA5C3.
REQ-034 Key 16'h0001 with parity bit 0 -> err=1, key_valid=0, key_out=0 after CHECK.
REQ-035 With TIMEOUT=8, stall key_bit_valid for 8 cycles after 5 bits -> ERROR, err=1, key_out=0.
REQ-036 Assert rst after 10 bits of 16'hFFFF -> all outputs 0 immediately; a reload of 16'h1234 then yields key_out=16'h1234.
REQ-037 Pulse start during SHIFT -> no restart; final key_out matches the originally shifted key.
REQ-038 Random valid gaps (<TIMEOUT) over 1000 random keys -> key_out equals the sent key whenever key_valid=1, and equals 0 otherwise.

Source files
------------

// File: rtl/rll_key_pkg.sv
// Shared definitions for the serial key loader: FSM state type and
// default key width / inter-bit timeout.
package rll_key_pkg;

   localparam int KEY_W_DEF   = 16;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHIFT  = 3'd1,
      ST_CHECK  = 3'd2,
      ST_LOADED = 3'd3,
      ST_ERROR  = 3'd4
   } rll_state_t;

endpackage

// File: rtl/rll_key_shreg.sv
// Serial key shadow register: bits arrive LSB first and enter at the MSB
// end, so after KEY_W+1 shifts the key sits in [KEY_W-1:0] and the parity
// bit in [KEY_W]. The odd-parity flag covers all KEY_W+1 bits.
module rll_key_shreg
   import rll_key_pkg::*;
#(
   parameter int KEY_W = KEY_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_shift,
   input  logic             i_bit,
   output logic [KEY_W-1:0] o_key,
   output logic             o_parity_err
);

   logic [KEY_W:0] r_shadow;

   // Shadow register: cleared at the start of each load, shifted per transfer.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shadow <= '0;
      end else if (i_clr) begin
         r_shadow <= '0;
      end else if (i_shift) begin
         r_shadow <= {i_bit, r_shadow[KEY_W:1]};
      end
   end

   assign o_key        = r_shadow[KEY_W-1:0];
   assign o_parity_err = ^r_shadow;

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader for a logic-locked netlist. Receives KEY_W key bits plus
// one even-parity bit, checks parity, and only then presents the key on
// o_key_out; every other state drives an all-zero key.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for i_start, key_out held at zero
// ST_SHIFT  | accepting serial bits, inter-bit timeout running
// ST_CHECK  | one cycle, parity of the full shadow register evaluated
// ST_LOADED | parity good, key_out drives the key, key_valid high
// ST_ERROR  | parity bad or timeout, err high, key_out zero
module rll_key_loader
   import rll_key_pkg::*;
#(
   parameter int KEY_W   = KEY_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_key_bit,
   input  logic             i_key_bit_valid,
   output logic             o_key_bit_ready,
   output logic [KEY_W-1:0] o_key_out,
   output logic             o_key_valid,
   output logic             o_busy,
   output logic             o_err
);

   localparam int CNT_W = $clog2(KEY_W + 2);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   // The transfer seen while the count equals KEY_W is the parity bit.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W);
   // An idle cycle seen at TIMEOUT-1 brings the count to TIMEOUT.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   rll_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [TMO_W-1:0] r_tmo;
   logic [KEY_W-1:0] r_key_out;
   logic             r_key_valid;
   logic             r_busy;
   logic             r_err;
   logic             r_ready;

   logic             w_xfer;
   logic             w_load_start;
   logic [KEY_W-1:0] w_shadow_key;
   logic             w_parity_err;

   // r_ready is high exactly in ST_SHIFT, so it doubles as the state qualifier.
   assign w_xfer       = r_ready & i_key_bit_valid;
   assign w_load_start = i_start & ((r_state == ST_IDLE) ||
                                    (r_state == ST_LOADED) ||
                                    (r_state == ST_ERROR));

   rll_key_shreg #(
      .KEY_W (KEY_W)
   ) u_shreg (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clr        (w_load_start),
      .i_shift      (w_xfer),
      .i_bit        (i_key_bit),
      .o_key        (w_shadow_key),
      .o_parity_err (w_parity_err)
   );

   // Sequencing FSM with bit/timeout counters and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_tmo       <= '0;
         r_key_out   <= '0;
         r_key_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_ready     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_LOADED, ST_ERROR: begin
               if (i_start) begin
                  r_state     <= ST_SHIFT;
                  r_cnt       <= '0;
                  r_tmo       <= '0;
                  r_key_out   <= '0;
                  r_key_valid <= 1'b0;
                  r_err       <= 1'b0;
                  r_busy      <= 1'b1;
                  r_ready     <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (w_xfer) begin
                  r_tmo <= '0;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_LAST) begin
                     r_state <= ST_CHECK;
                     r_ready <= 1'b0;
                  end
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
                  if (r_tmo == TMO_LAST) begin
                     r_state <= ST_ERROR;
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b0;
                  end
               end
            end
            ST_CHECK: begin
               r_busy <= 1'b0;
               if (w_parity_err) begin
                  r_state <= ST_ERROR;
                  r_err   <= 1'b1;
               end else begin
                  r_state     <= ST_LOADED;
                  r_key_out   <= w_shadow_key;
                  r_key_valid <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_key_bit_ready = r_ready;
   assign o_key_out       = r_key_out;
   assign o_key_valid     = r_key_valid;
   assign o_busy          = r_busy;
   assign o_err           = r_err;

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader: directed boundary steps followed by
// 1000 random keys with random valid gaps and occasional corrupted parity.
module tb_rll_key_loader;

   localparam int KW  = 16;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          kbit;
   logic          kvalid;
   logic          ready;
   logic [KW-1:0] key_out;
   logic          key_valid;
   logic          busy;
   logic          err;

   int n_assert = 0;
   int n_fail   = 0;

   rll_key_loader #(
      .KEY_W   (KW),
      .TIMEOUT (TMO)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_start         (start),
      .i_key_bit       (kbit),
      .i_key_bit_valid (kvalid),
      .o_key_bit_ready (ready),
      .o_key_out       (key_out),
      .o_key_valid     (key_valid),
      .o_busy          (busy),
      .o_err           (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: the parity bit that makes key+parity even.
   function automatic logic even_par(input logic [KW-1:0] k);
      return logic'($countones(k) % 2);
   endfunction

   // Mid-load expectations: busy, nothing exposed.
   task automatic mon_loading(input string tag);
      chk({tag, "_busy"},  32'(busy), 32'd1);
      chk({tag, "_kv"},    32'(key_valid), 32'd0);
      chk({tag, "_kout"},  32'(key_out), 32'd0);
      chk({tag, "_err"},   32'(err), 32'd0);
   endtask

   task automatic send_bit(input logic b, input int gap);
      for (int g = 0; g < gap; g++) begin
         kvalid = 1'b0;
         kbit   = 1'($urandom);
         tick();
         mon_loading("gap");
      end
      kvalid = 1'b1;
      kbit   = b;
      tick();
      mon_loading("xfer");
      kvalid = 1'b0;
   endtask

   // One complete load; start edge counts as cycle 1, the 17 transfers as
   // cycles 2..18 (CHECK after the last one), key_valid visible at cycle 19.
   task automatic load_key(input logic [KW-1:0] key, input logic par,
                           input bit gaps, input int poke_at);
      logic [KW:0] bits;
      logic        ok;
      int          gap;
      bits  = {par, key};
      ok    = ($countones(bits) % 2) == 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_kout",  32'(key_out), 32'd0);
      chk("start_kv",    32'(key_valid), 32'd0);
      chk("start_err",   32'(err), 32'd0);
      chk("start_busy",  32'(busy), 32'd1);
      chk("start_ready", 32'(ready), 32'd1);
      for (int i = 0; i <= KW; i++) begin
         gap = 0;
         if (gaps && $urandom_range(0, 3) == 0) gap = $urandom_range(1, TMO - 1);
         if (i == poke_at) start = 1'b1;
         send_bit(bits[i], gap);
         start = 1'b0;
      end
      chk("check_ready", 32'(ready), 32'd0);
      tick();
      chk("done_kv",    32'(key_valid), 32'(ok));
      chk("done_err",   32'(err), 32'(!ok));
      chk("done_kout",  32'(key_out), ok ? 32'(key) : 32'd0);
      chk("done_busy",  32'(busy), 32'd0);
      chk("done_ready", 32'(ready), 32'd0);
   endtask

   initial begin
      logic [KW-1:0] k;
      logic          p;
      logic          ok;
      logic [KW-1:0] ffff;
      rst    = 1'b1;
      start  = 1'b0;
      kbit   = 1'b0;
      kvalid = 1'b0;
      tick();
      tick();
      chk("rst_kout",  32'(key_out), 32'd0);
      chk("rst_kv",    32'(key_valid), 32'd0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_err",   32'(err), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      rst = 1'b0;

      // key_bit_valid ignored while idle
      kvalid = 1'b1;
      kbit   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_ready", 32'(ready), 32'd0);
         chk("idle_busy",  32'(busy), 32'd0);
         chk("idle_kout",  32'(key_out), 32'd0);
      end
      kvalid = 1'b0;

      // Back-to-back good key, exact latency checked inside load_key
      load_key(16'hA5C3, 1'b0, 1'b0, -1);
      // Hold in LOADED while idle inputs wiggle
      kvalid = 1'b1;
      tick();
      kvalid = 1'b0;
      chk("loaded_hold", 32'(key_out), 32'h0000A5C3);
      chk("loaded_ready", 32'(ready), 32'd0);

      // Bad parity from LOADED (start clears key_out/key_valid)
      load_key(16'h0001, 1'b0, 1'b0, -1);
      // Good key from ERROR (start clears err)
      load_key(16'h5A5A, even_par(16'h5A5A), 1'b0, -1);

      // Timeout boundary: 7 idle cycles survive, a transfer on the 8th wins
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) send_bit(1'b1, 0);
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         mon_loading("tmo_prio_idle");
      end
      for (int i = 2; i <= KW; i++) send_bit((i == KW) ? 1'b0 : 1'b0, 0);
      tick();
      chk("tmo_prio_kv",   32'(key_valid), 32'd1);
      chk("tmo_prio_kout", 32'(key_out), 32'h00000003);

      // Timeout: 5 bits then 8 stalled cycles
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         mon_loading("tmo_idle");
      end
      chk("tmo_pre_ready", 32'(ready), 32'd1);
      tick();
      chk("tmo_err",   32'(err), 32'd1);
      chk("tmo_busy",  32'(busy), 32'd0);
      chk("tmo_kout",  32'(key_out), 32'd0);
      chk("tmo_kv",    32'(key_valid), 32'd0);
      chk("tmo_ready", 32'(ready), 32'd0);

      // Reset mid-load after 10 bits of 16'hFFFF
      ffff  = 16'hFFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) send_bit(ffff[i], 0);
      rst = 1'b1;
      #1;
      chk("midrst_kout",  32'(key_out), 32'd0);
      chk("midrst_kv",    32'(key_valid), 32'd0);
      chk("midrst_busy",  32'(busy), 32'd0);
      chk("midrst_err",   32'(err), 32'd0);
      chk("midrst_ready", 32'(ready), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      load_key(16'h1234, even_par(16'h1234), 1'b0, -1);

      // start pulsed mid-shift is ignored
      load_key(16'hC0DE, even_par(16'hC0DE), 1'b1, 6);

      // Random keys, random gaps below the timeout, ~1/8 corrupted parity
      for (int n = 0; n < 1000; n++) begin
         k  = 16'($urandom);
         p  = even_par(k) ^ ($urandom_range(0, 7) == 0);
         ok = (p == even_par(k));
         load_key(k, p, 1'b1, -1);
         for (int j = $urandom_range(0, 2); j > 0; j--) begin
            kvalid = 1'($urandom);
            kbit   = 1'($urandom);
            tick();
            chk("rand_hold_kout", 32'(key_out), ok ? 32'(k) : 32'd0);
            chk("rand_hold_kv",   32'(key_valid), 32'(ok));
         end
         kvalid = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
